// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: request-interface responder driving a timed 16-bit async SRAM access.
// Ports:
//   clk, reset_n                  - clock (rising edge), async active-low reset
//   modeOutput                    - request: 00 idle, 01 read, 10 write, 11 ignored
//   memoryAddress, write_data     - request operands, latched on acceptance
//   memDone                       - 1 when idle/ready or access complete
//   read_data                     - data captured by the last completed read
//   memAddr, memDqOut, memDqOe    - external address, write data and data-pin drive enable
//   memDqIn                       - external read data
//   memCe_n, memOe_n, memWe_n     - active-low chip, output and write enables
module mem_access_ctrl #(
  parameter int ADDR_W      = 25,
  parameter int DATA_W      = 16,
  parameter int WAIT_CYCLES = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [1:0]        modeOutput,
  input  logic [ADDR_W-1:0] memoryAddress,
  input  logic [DATA_W-1:0] write_data,
  output logic              memDone,
  output logic [DATA_W-1:0] read_data,
  output logic [ADDR_W-1:0] memAddr,
  output logic [DATA_W-1:0] memDqOut,
  input  logic [DATA_W-1:0] memDqIn,
  output logic              memDqOe,
  output logic              memCe_n,
  output logic              memOe_n,
  output logic              memWe_n
);
  typedef enum logic [2:0] {IDLE, RD_SETUP, RD_STROBE, WR_SETUP, WR_STROBE, WR_HOLD, DONE} state_t;
  localparam logic [3:0] LOAD = 4'(WAIT_CYCLES - 1);
  state_t     state;
  logic [3:0] cnt;
  // Outputs are registered, so each state's pin levels appear one clock after the
  // state is entered; the strobe counter only runs once the strobe pin is already low.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      memDone   <= 1'b1;
      read_data <= '0;
      memAddr   <= '0;
      memDqOut  <= '0;
      memDqOe   <= 1'b0;
      memCe_n   <= 1'b1;
      memOe_n   <= 1'b1;
      memWe_n   <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (modeOutput == 2'b01) begin
            memAddr <= memoryAddress;
            memDone <= 1'b0;
            state   <= RD_SETUP;
          end else if (modeOutput == 2'b10) begin
            memAddr  <= memoryAddress;
            memDqOut <= write_data;
            memDone  <= 1'b0;
            state    <= WR_SETUP;
          end
        end
        RD_SETUP: begin
          memCe_n <= 1'b0;
          cnt     <= LOAD;
          state   <= RD_STROBE;
        end
        RD_STROBE: begin
          memOe_n <= 1'b0;
          if (!memOe_n) begin
            if (cnt == 4'd0) begin
              read_data <= memDqIn;
              memOe_n   <= 1'b1;
              memCe_n   <= 1'b1;
              memDone   <= 1'b1;
              state     <= DONE;
            end else cnt <= cnt - 4'd1;
          end
        end
        WR_SETUP: begin
          memCe_n <= 1'b0;
          memDqOe <= 1'b1;
          cnt     <= LOAD;
          state   <= WR_STROBE;
        end
        WR_STROBE: begin
          memWe_n <= 1'b0;
          if (!memWe_n) begin
            if (cnt == 4'd0) begin
              memWe_n <= 1'b1;
              state   <= WR_HOLD;
            end else cnt <= cnt - 4'd1;
          end
        end
        WR_HOLD: begin
          memDqOe <= 1'b0;
          memCe_n <= 1'b1;
          memDone <= 1'b1;
          state   <= DONE;
        end
        DONE: state <= (modeOutput == 2'b00) ? IDLE : DONE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: randomized self-checking bench for mem_access_ctrl against a transaction-level model.
module tb_mem_access_ctrl;
  localparam int AW = 25;
  localparam int DW = 16;
  localparam int W  = 4;
  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [1:0]    modeOutput = 2'b00;
  logic [AW-1:0] memoryAddress = '0;
  logic [DW-1:0] write_data = '0;
  logic [DW-1:0] memDqIn = 16'h0BAD;
  logic          memDone, memDqOe, memCe_n, memOe_n, memWe_n;
  logic [DW-1:0] read_data, memDqOut;
  logic [AW-1:0] memAddr;
  int            n_tests = 0;
  int            n_fail = 0;
  logic [DW-1:0] ref_mem [logic [AW-1:0]];
  logic [DW-1:0] bus_mem [logic [AW-1:0]];
  logic [DW-1:0] exp_rd = '0;
  logic [AW-1:0] pool [4] = '{25'h1FFFFFF, 25'h0000123, 25'h0ABCDEF, 25'h0000000};

  always #5 clk = ~clk;

  mem_access_ctrl #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(W)) dut (
    .clk(clk), .reset_n(reset_n), .modeOutput(modeOutput), .memoryAddress(memoryAddress),
    .write_data(write_data), .memDone(memDone), .read_data(read_data), .memAddr(memAddr),
    .memDqOut(memDqOut), .memDqIn(memDqIn), .memDqOe(memDqOe), .memCe_n(memCe_n),
    .memOe_n(memOe_n), .memWe_n(memWe_n)
  );

  function automatic logic [DW-1:0] dflt(input logic [AW-1:0] a);
    return a[15:0] ^ 16'h5A5A;
  endfunction

  always @(negedge clk)
    memDqIn = !memOe_n ? (bus_mem.exists(memAddr) ? bus_mem[memAddr] : dflt(memAddr)) : 16'h0BAD;

  always @(posedge memWe_n)
    if (reset_n === 1'b1 && memDqOe === 1'b1) bus_mem[memAddr] = memDqOut;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_op(input logic [1:0] mode, input logic [AW-1:0] a, input logic [DW-1:0] d, input int hold);
    int lat = 0, oe = 0, we = 0, dq = 0, bad_addr = 0, bad_dq = 0, both = 0, busy = 0;
    modeOutput = mode;
    memoryAddress = a;
    write_data = d;
    @(posedge clk); #1;
    while (!memDone && lat < 40) begin
      lat++;
      if (!memOe_n) oe++;
      if (!memWe_n) begin
        we++;
        if (memDqOut !== d) bad_dq++;
      end
      if (memDqOe) dq++;
      if (memAddr !== a) bad_addr++;
      if (!memOe_n && !memWe_n) both++;
      memoryAddress = AW'($urandom);
      write_data = DW'($urandom);
      @(posedge clk); #1;
    end
    if (mode == 2'b01) exp_rd = ref_mem.exists(a) ? ref_mem[a] : dflt(a);
    else ref_mem[a] = d;
    chk("latency", lat, mode == 2'b01 ? W + 2 : W + 3);
    chk("oe_low_cycles", oe, mode == 2'b01 ? W : 0);
    chk("we_low_cycles", we, mode == 2'b10 ? W : 0);
    chk("dqoe_cycles", dq, mode == 2'b10 ? W + 2 : 0);
    chk("addr_stable", bad_addr, 0);
    chk("write_data_on_bus", bad_dq, 0);
    chk("strobe_exclusive", both, 0);
    chk("read_data", read_data, exp_rd);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      if (!memDone || !memCe_n) busy++;
    end
    chk("held_request_once", busy, 0);
    modeOutput = 2'b00;
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int k, ce_act;
    logic [1:0] m;
    logic [AW-1:0] a;
    bus_mem[25'h1FFFFFF] = 16'hAAAA;
    ref_mem[25'h1FFFFFF] = 16'hAAAA;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_done", memDone, 1);
    chk("rst_read_data", read_data, 0);
    chk("rst_ce", memCe_n, 1);
    chk("rst_oe", memOe_n, 1);
    chk("rst_we", memWe_n, 1);
    chk("rst_dqoe", memDqOe, 0);
    chk("rst_addr", memAddr, 0);
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1;
    do_op(2'b01, 25'h1FFFFFF, 16'h0000, 0);
    do_op(2'b10, 25'h0000123, 16'h5A5A, 0);
    do_op(2'b01, 25'h0000123, 16'h0000, 0);
    do_op(2'b01, 25'h0ABCDEF, 16'h0000, 20);
    do_op(2'b10, 25'h0ABCDEF, 16'hC3C3, 2);
    modeOutput = 2'b11;
    ce_act = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (!memDone || !memCe_n || !memOe_n || !memWe_n || memDqOe) ce_act++;
    end
    chk("mode11_ignored", ce_act, 0);
    modeOutput = 2'b00;
    @(posedge clk); #1;
    for (int t = 0; t < 30; t++) begin
      m = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
      a = ($urandom_range(0, 4) == 4) ? AW'($urandom) : pool[$urandom_range(0, 3)];
      do_op(m, a, DW'($urandom), $urandom_range(0, 3));
    end
    modeOutput = 2'b10;
    memoryAddress = 25'h1555555;
    write_data = 16'h1234;
    k = 0;
    @(posedge clk); #1;
    while (memWe_n && k < 10) begin
      @(posedge clk); #1;
      k++;
    end
    chk("we_reached", memWe_n, 0);
    reset_n = 1'b0;
    #1;
    chk("abort_we", memWe_n, 1);
    chk("abort_dqoe", memDqOe, 0);
    chk("abort_done", memDone, 1);
    chk("abort_ce", memCe_n, 1);
    chk("abort_read_data", read_data, 0);
    exp_rd = '0;
    modeOutput = 2'b00;
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1;
    do_op(2'b01, 25'h0000123, 16'h0000, 0);
    do_op(2'b01, 25'h1FFFFFF, 16'h0000, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
